// File: rtl/servo_pwm_sequencer_pkg.sv
// servo_pkg: shared timing defaults, FSM state type and position clamp helper.
//   DEF_*      default parameter values for servo_pwm_sequencer
//   state_t    sequencer state (IDLE between pulse trains, PULSE while a channel is high)
//   clamp_pos  maps an 8-bit position offset to a pulse width in ticks
package servo_pkg;
    localparam int DEF_NUM_CH          = 4;
    localparam int DEF_TICKS_PER_FRAME = 2000;
    localparam int DEF_MIN_PULSE       = 100;
    localparam int DEF_MAX_PULSE       = 200;
    localparam int DEF_SLEW_STEP       = 2;
    localparam int DEF_CW              = 12;

    typedef enum logic {IDLE, PULSE} state_t;

    function automatic int clamp_pos(input logic [7:0] pos, input int min_p, input int max_p);
        return min_p + ((int'(pos) > max_p - min_p) ? max_p - min_p : int'(pos));
    endfunction
endpackage

// File: rtl/servo_slew_step.sv
// servo_slew_step: moves a channel width toward its target by at most SLEW_STEP.
//   cur       current width in ticks
//   target    requested width in ticks
//   cur_next  width for the next frame
module servo_slew_step #(
    parameter int CW        = 12,
    parameter int SLEW_STEP = 2
) (
    input  logic [CW-1:0] cur,
    input  logic [CW-1:0] target,
    output logic [CW-1:0] cur_next
);
    logic          up;
    logic [CW-1:0] diff;

    always_comb begin
        up       = target > cur;
        diff     = up ? target - cur : cur - target;
        cur_next = (diff > CW'(SLEW_STEP)) ? (up ? cur + CW'(SLEW_STEP) : cur - CW'(SLEW_STEP)) : target;
    end
endmodule

// File: rtl/servo_pwm_sequencer.sv
// servo_pwm_sequencer: frame-based multi-channel servo pulse scheduler with slew-limited targets.
//   clock        system clock
//   reset_n      asynchronous active-low reset
//   tick         single-cycle time-base enable
//   wr_valid     position write request
//   wr_ready     write accept (high whenever out of reset)
//   wr_ch        target channel; indices >= NUM_CH are accepted and dropped
//   wr_pos       position offset above MIN_PULSE, clamped to the pulse range
//   servo_out    one PWM line per channel, pulses fired back-to-back each frame
//   frame_start  one-clock pulse on each frame boundary
//   busy         high while a channel pulse is in progress
module servo_pwm_sequencer
    import servo_pkg::*;
#(
    parameter int NUM_CH          = DEF_NUM_CH,
    parameter int TICKS_PER_FRAME = DEF_TICKS_PER_FRAME,
    parameter int MIN_PULSE       = DEF_MIN_PULSE,
    parameter int MAX_PULSE       = DEF_MAX_PULSE,
    parameter int SLEW_STEP       = DEF_SLEW_STEP,
    parameter int CW              = DEF_CW
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              tick,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [2:0]        wr_ch,
    input  logic [7:0]        wr_pos,
    output logic [NUM_CH-1:0] servo_out,
    output logic              frame_start,
    output logic              busy
);
    localparam int            IW  = $clog2(NUM_CH);
    localparam logic [CW-1:0] MID = CW'((MIN_PULSE + MAX_PULSE) / 2);
    localparam logic [CW-1:0] TOP = CW'(TICKS_PER_FRAME - 1);

    if (NUM_CH * MAX_PULSE >= TICKS_PER_FRAME || MIN_PULSE > MAX_PULSE || MIN_PULSE < 1 ||
        SLEW_STEP < 1 || NUM_CH < 2 || NUM_CH > 8 || (64'd1 << CW) <= 64'(TICKS_PER_FRAME)) begin : g_bad_params
        $error("servo_pwm_sequencer: illegal parameter combination");
    end

    state_t        state;
    logic [IW-1:0] ch_idx;
    logic [CW-1:0] pulse_cnt;
    logic [CW-1:0] frame_cnt;
    logic [CW-1:0] target   [NUM_CH];
    logic [CW-1:0] cur      [NUM_CH];
    logic [CW-1:0] cur_next [NUM_CH];
    logic          frame_edge;

    assign frame_edge = tick && frame_cnt == TOP;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        servo_slew_step #(.CW(CW), .SLEW_STEP(SLEW_STEP)) u_slew (
            .cur      (cur[g]),
            .target   (target[g]),
            .cur_next (cur_next[g])
        );
    end

    // Targets written on a frame edge land after the slew sample, so they apply next frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                target[k] <= MID;
                cur[k]    <= MID;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (wr_valid && wr_ready && wr_ch == 3'(k))
                    target[k] <= CW'(clamp_pos(wr_pos, MIN_PULSE, MAX_PULSE));
                if (frame_edge)
                    cur[k] <= cur_next[k];
            end
        end
    end

    // The active width is read from cur[], which only changes on frame edges (while IDLE).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            ch_idx      <= '0;
            pulse_cnt   <= '0;
            frame_cnt   <= TOP;
            servo_out   <= '0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            wr_ready    <= 1'b0;
        end else begin
            wr_ready    <= 1'b1;
            frame_start <= frame_edge;
            if (tick)
                frame_cnt <= (frame_cnt == TOP) ? '0 : frame_cnt + CW'(1);
            case (state)
                IDLE: if (frame_edge) begin
                    state     <= PULSE;
                    ch_idx    <= '0;
                    pulse_cnt <= '0;
                    servo_out <= NUM_CH'(1);
                    busy      <= 1'b1;
                end
                PULSE: if (tick) begin
                    if (pulse_cnt + CW'(1) == cur[ch_idx]) begin
                        pulse_cnt <= '0;
                        if (ch_idx != IW'(NUM_CH - 1)) begin
                            ch_idx    <= ch_idx + IW'(1);
                            servo_out <= servo_out << 1;
                        end else begin
                            state     <= IDLE;
                            servo_out <= '0;
                            busy      <= 1'b0;
                        end
                    end else begin
                        pulse_cnt <= pulse_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_edge_in_idle: assert property (@(posedge clock) disable iff (!reset_n) frame_edge |-> state == IDLE);
endmodule

// File: doc/servo_pwm_sequencer.md
Name: servo_pwm_sequencer

Overview:
Multi-channel servo pulse scheduler for the DE1-SoC servo controller. It consumes a single-cycle time-base enable (`tick`) from the clock-division stage and builds a repeating servo frame. Within each frame it fires one pulse per channel in sequence, so only one servo output is high at any time. Position targets arrive over a valid/ready write port, are slew-limited, and take effect only at frame boundaries.

Parameters:
- NUM_CH, 4, number of servo channels (2..8).
- TICKS_PER_FRAME, 2000, frame length in ticks (20 ms at a 10 us tick).
- MIN_PULSE, 100, minimum pulse width in ticks (1 ms).
- MAX_PULSE, 200, maximum pulse width in ticks (2 ms).
- SLEW_STEP, 2, maximum width change per channel per frame, in ticks.
- CW, 12, counter/width bit width; must satisfy 2^CW > TICKS_PER_FRAME.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- tick  in  1  single-cycle time-base enable; ignored when low.
- wr_valid  in  1  position write request.
- wr_ready  out  1  write accept.
- wr_ch  in  3  target channel index.
- wr_pos  in  8  requested position offset above MIN_PULSE.
- servo_out  out  NUM_CH  one PWM line per channel.
- frame_start  out  1  one-clock pulse on each frame boundary.
- busy  out  1  high while a channel pulse is in progress.

Behaviour:
- Elaboration checks: NUM_CH*MAX_PULSE < TICKS_PER_FRAME, MIN_PULSE <= MAX_PULSE, SLEW_STEP >= 1. Violation causes an elaboration error.
- Reset (asynchronous, reset_n=0):
  - servo_out=0, frame_start=0, busy=0, wr_ready=0.
  - All target[] and cur[] = (MIN_PULSE+MAX_PULSE)/2.
  - frame_cnt = TICKS_PER_FRAME-1, so the first tick after reset opens a frame.
  - FSM = IDLE.
- wr_ready is 1 in every cycle after reset is released.
- Write accept: on a clock edge with wr_valid & wr_ready:
  - If wr_ch < NUM_CH, target[wr_ch] = MIN_PULSE + min(wr_pos, MAX_PULSE-MIN_PULSE).
  - If wr_ch >= NUM_CH, the write is accepted and dropped.
- Frame counter: advances only on tick. It wraps from TICKS_PER_FRAME-1 to 0, and that wrap is the frame edge.
- Frame edge, all updates in the same clock edge:
  - frame_start=1 for exactly one clock.
  - Each cur[k] moves toward target[k] by min(|target-cur|, SLEW_STEP).
  - servo_out[0] rises.
  - FSM goes IDLE to PULSE with ch_idx=0 and pulse_cnt=0.
- A write accepted on the same edge as a frame edge is not seen by that frame's slew update; it is applied from the next frame.
- FSM IDLE: all outputs low, busy=0. Waits for the frame edge.
- FSM PULSE:
  - busy=1; servo_out[ch_idx] is high and all other bits are low.
  - Each tick increments pulse_cnt.
  - On the tick where pulse_cnt+1 == width, servo_out[ch_idx] falls. The width used is the cur[] value latched at the frame edge.
  - If ch_idx < NUM_CH-1: on that same edge ch_idx increments, pulse_cnt clears, and the next channel rises. Channels are back-to-back, with no gap and no overlap.
  - Otherwise the FSM goes to IDLE and busy falls.
- Pulse width: each channel's output is high for exactly cur[k] tick periods, measured between tick edges.
- The sequence always completes before the next frame edge (guaranteed by the elaboration check). A frame edge seen outside IDLE is unreachable and is covered by an assertion.
- cur[] is never modified mid-frame.
- tick held continuously high: the block operates correctly with one tick per clock.
- Reset asserted mid-pulse: servo_out drops immediately (asynchronously), and the whole state returns to reset values.

Decomposition:
- Package servo_pkg holds:
  - the default constants for frame and pulse timing;
  - state enum {IDLE, PULSE};
  - function clamp_pos(pos) returning the target width.
- One sub-module, servo_slew_step, instanced per channel. It is combinational: it takes cur and target and returns the next cur, limited to ±SLEW_STEP.
- The tick source stays external (the existing clock-division stage).

Test Plan:
Every test below uses bench parameters NUM_CH=2, TICKS_PER_FRAME=40, MIN_PULSE=4, MAX_PULSE=8, SLEW_STEP=1, with tick every 3rd clock unless stated otherwise.
1. Reset release, no writes -> first tick gives frame_start; ch0 is high for 6 ticks, then ch1 is high for 6 ticks with no gap; busy is high for 12 ticks; the next frame_start comes 40 ticks later.
2. Write ch0 with pos=255 -> target is clamped to 8; cur[0] reads 7 in the next frame and 8 in the frame after that; it stays at 8 afterwards.
3. Write ch1 with pos=0 on the same clock edge as a frame edge -> that frame still gives 6 ticks on ch1; the following frames give 5 and then 4.
4. Write with wr_ch=3 -> accepted (wr_ready=1), no change to any width.
5. Pull reset_n low in the middle of the ch0 pulse -> servo_out is 0 in the same cycle; after release, the first tick restarts a frame with widths of 6.
6. tick tied high, 1000 clocks -> at most one servo_out bit is high at any cycle; every frame is 40 clocks long.
